// File: rtl/mem_access_ctrl_m_if.sv
// Memory-side bus of the M-stage access controller: registered request
// fields driven by the controller, read data and completion from memory.
interface mem_access_ctrl_m_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_byteen;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_ctrl_m.sv
// M-stage memory access controller: decodes loads/stores, issues one bus
// request per access, stalls the pipeline until ack or timeout.
module mem_access_ctrl_m #(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr_M,
  input  logic                 valid_M,
  input  logic [ADDR_W-1:0]    alu_result_M,
  input  logic [31:0]          rt_data_M,
  input  logic [4:0]           reg_addr_W,
  input  logic [31:0]          reg_data_W,
  mem_access_ctrl_m_if.master  mem,
  output logic                 stall_M,
  output logic [31:0]          load_data,
  output logic                 load_valid,
  output logic [4:0]           reg_addr,
  output logic                 fwd_rt_data_M_op,
  output logic                 exc_adel,
  output logic                 exc_ades,
  output logic                 bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          op_load_q;
  logic          op_signed_q;
  logic [1:0]    op_size_q;
  logic [1:0]    addr_lo_q;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        is_load, is_store, is_byte, is_half, is_word;
  logic        misaligned, mem_op, go;
  logic [31:0] store_data;
  logic [3:0]  byteen_c;
  logic [31:0] wdata_c;
  logic [31:0] byte_shift;
  logic [31:0] load_ext;

  assign opcode = instr_M[31:26];
  assign funct  = instr_M[5:0];
  assign rt     = instr_M[20:16];
  assign rd     = instr_M[15:11];

  assign is_load  = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
                    (opcode == OP_LBU) || (opcode == OP_LHU);
  assign is_store = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
  assign is_byte  = (opcode == OP_LB) || (opcode == OP_LBU) || (opcode == OP_SB);
  assign is_half  = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
  assign is_word  = (opcode == OP_LW) || (opcode == OP_SW);

  assign misaligned = (is_word && (alu_result_M[1:0] != 2'b00)) || (is_half && alu_result_M[0]);
  assign mem_op     = valid_M && (is_load || is_store);
  assign go         = (state == S_IDLE) && mem_op && !misaligned;

  assign exc_adel = (state == S_IDLE) && mem_op && is_load  && misaligned;
  assign exc_ades = (state == S_IDLE) && mem_op && is_store && misaligned;
  assign stall_M  = go || (state == S_REQ);

  assign fwd_rt_data_M_op = (rt == reg_addr_W) && (rt != 5'd0);
  assign store_data       = fwd_rt_data_M_op ? reg_data_W : rt_data_M;

  always_comb begin
    reg_addr = 5'd0;
    if (opcode == OP_RTYPE && (funct == 6'b100000 || funct == 6'b100010 || funct == 6'b000000))
      reg_addr = rd;
    else if (opcode == OP_ORI || opcode == OP_LUI || is_load)
      reg_addr = rt;
    else if (opcode == OP_JAL)
      reg_addr = 5'd31;
  end

  // Narrow stores replicate their data across the word so memory picks lanes by byteen alone.
  always_comb begin
    byteen_c = 4'b0000;
    wdata_c  = store_data;
    if (is_store) begin
      if (is_byte) begin
        byteen_c = 4'b0001 << alu_result_M[1:0];
        wdata_c  = {4{store_data[7:0]}};
      end else if (is_half) begin
        byteen_c = alu_result_M[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{store_data[15:0]}};
      end else begin
        byteen_c = 4'b1111;
      end
    end
  end

  assign byte_shift = mem.mem_rdata >> {addr_lo_q, 3'b000};

  always_comb begin
    load_ext = mem.mem_rdata;
    case (op_size_q)
      2'd0: load_ext = {{24{op_signed_q & byte_shift[7]}}, byte_shift[7:0]};
      2'd1: load_ext = addr_lo_q[1] ?
                       {{16{op_signed_q & mem.mem_rdata[31]}}, mem.mem_rdata[31:16]} :
                       {{16{op_signed_q & mem.mem_rdata[15]}}, mem.mem_rdata[15:0]};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  // An ack on the same cycle the wait budget runs out wins over the timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      op_load_q      <= 1'b0;
      op_signed_q    <= 1'b0;
      op_size_q      <= 2'd0;
      addr_lo_q      <= 2'd0;
      mem.mem_req    <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_byteen <= 4'b0000;
      mem.mem_wdata  <= 32'd0;
      load_data      <= 32'd0;
      load_valid     <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            state          <= S_REQ;
            wait_cnt       <= '0;
            op_load_q      <= is_load;
            op_signed_q    <= (opcode == OP_LB) || (opcode == OP_LH);
            op_size_q      <= is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
            addr_lo_q      <= alu_result_M[1:0];
            mem.mem_req    <= 1'b1;
            mem.mem_we     <= is_store;
            mem.mem_addr   <= {alu_result_M[ADDR_W-1:2], 2'b00};
            mem.mem_byteen <= byteen_c;
            mem.mem_wdata  <= wdata_c;
          end
        end
        S_REQ: begin
          if (mem.mem_ack) begin
            state       <= S_DONE;
            mem.mem_req <= 1'b0;
            load_valid  <= op_load_q;
            if (op_load_q)
              load_data <= load_ext;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state       <= S_DONE;
            wait_cnt    <= CW'(TIMEOUT);
            mem.mem_req <= 1'b0;
            load_valid  <= op_load_q;
            load_data   <= 32'd0;
            bus_err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          load_valid <= 1'b0;
          bus_err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl_m.sv
// Directed bench for mem_access_ctrl_m: loads, stores, forwarding,
// misalignment, timeout, ack-at-timeout and reset during a request.
module tb_mem_access_ctrl_m;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_M;
  logic        valid_M;
  logic [31:0] alu_result_M;
  logic [31:0] rt_data_M;
  logic [4:0]  reg_addr_W;
  logic [31:0] reg_data_W;
  logic        stall_M;
  logic [31:0] load_data;
  logic        load_valid;
  logic [4:0]  reg_addr;
  logic        fwd_rt_data_M_op;
  logic        exc_adel, exc_ades, bus_err;
  int          checks = 0;
  int          failures = 0;
  int          stall_cycles;

  mem_access_ctrl_m_if #(.ADDR_W(32)) bus ();

  mem_access_ctrl_m #(.TIMEOUT(15), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .instr_M(instr_M), .valid_M(valid_M),
    .alu_result_M(alu_result_M), .rt_data_M(rt_data_M),
    .reg_addr_W(reg_addr_W), .reg_data_W(reg_data_W), .mem(bus.master),
    .stall_M(stall_M), .load_data(load_data), .load_valid(load_valid),
    .reg_addr(reg_addr), .fwd_rt_data_M_op(fwd_rt_data_M_op),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd1, rt, 16'h0000};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [5:0] funct);
    return {6'b000000, 5'd1, 5'd2, rd, 5'd0, funct};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] instr, input logic valid,
                                input logic [31:0] addr, input logic [31:0] rtd);
    instr_M      = instr;
    valid_M      = valid;
    alu_result_M = addr;
    rt_data_M    = rtd;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Waits the given number of ack-less REQ cycles, then acks with rdata and lands in DONE.
  task automatic complete(input int waits, input logic [31:0] rdata);
    repeat (waits) tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    tick();
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'd0;
    reg_addr_W = 5'd0;
    reg_data_W = 32'd0;
    apply_stimulus(32'd0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    check_output("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check_output("rst_byteen", {28'd0, bus.mem_byteen}, 32'd0);
    check_output("rst_addr", bus.mem_addr, 32'd0);
    check_output("rst_load_data", load_data, 32'd0);
    check_output("rst_load_valid", {31'd0, load_valid}, 32'd0);
    check_output("rst_bus_err", {31'd0, bus_err}, 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] destination register decode");
    apply_stimulus(r_type(5'd5, 6'b100000), 1'b0, 32'd0, 32'd0);
    check_output("rd_add", {27'd0, reg_addr}, 32'd5);
    apply_stimulus(r_type(5'd6, 6'b100101), 1'b0, 32'd0, 32'd0);
    check_output("rd_or_none", {27'd0, reg_addr}, 32'd0);
    apply_stimulus(i_type(6'b001101, 5'd9), 1'b0, 32'd0, 32'd0);
    check_output("rd_ori", {27'd0, reg_addr}, 32'd9);
    apply_stimulus(i_type(6'b000011, 5'd4), 1'b0, 32'd0, 32'd0);
    check_output("rd_jal", {27'd0, reg_addr}, 32'd31);
    apply_stimulus(i_type(6'b101011, 5'd3), 1'b0, 32'd0, 32'd0);
    check_output("rd_sw", {27'd0, reg_addr}, 32'd0);

    $display("[TB] lw with three wait cycles");
    apply_stimulus(i_type(6'b100011, 5'd2), 1'b1, 32'h10, 32'd0);
    check_output("lw_rd", {27'd0, reg_addr}, 32'd2);
    check_output("lw_idle_req", {31'd0, bus.mem_req}, 32'd0);
    stall_cycles = int'(stall_M);
    tick();
    check_output("lw_req", {31'd0, bus.mem_req}, 32'd1);
    check_output("lw_addr", bus.mem_addr, 32'h10);
    check_output("lw_we", {31'd0, bus.mem_we}, 32'd0);
    check_output("lw_byteen", {28'd0, bus.mem_byteen}, 32'd0);
    stall_cycles += int'(stall_M);
    repeat (3) begin
      tick();
      stall_cycles += int'(stall_M);
    end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h12345678;
    tick();
    bus.mem_ack = 1'b0;
    valid_M = 1'b0;
    #1;
    stall_cycles += int'(stall_M);
    check_output("lw_stall_total", stall_cycles, 32'd5);
    check_output("lw_data", load_data, 32'h12345678);
    check_output("lw_valid", {31'd0, load_valid}, 32'd1);
    check_output("lw_done_req", {31'd0, bus.mem_req}, 32'd0);
    tick();
    check_output("lw_valid_pulse", {31'd0, load_valid}, 32'd0);

    $display("[TB] lb then lbu, ack held from IDLE");
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h80FF00AA;
    apply_stimulus(i_type(6'b100000, 5'd3), 1'b1, 32'h13, 32'd0);
    tick();
    check_output("lb_idle_ack_ignored", {31'd0, bus.mem_req}, 32'd1);
    tick();
    bus.mem_ack = 1'b0;
    apply_stimulus(i_type(6'b100100, 5'd3), 1'b1, 32'h13, 32'd0);
    check_output("lb_data", load_data, 32'hFFFFFF80);
    check_output("lb_done_stall", {31'd0, stall_M}, 32'd0);
    tick();
    check_output("done_no_new_req", {31'd0, bus.mem_req}, 32'd0);
    check_output("lbu_idle_stall", {31'd0, stall_M}, 32'd1);
    tick();
    complete(0, 32'h80FF00AA);
    valid_M = 1'b0;
    check_output("lbu_data", load_data, 32'h00000080);
    tick();

    apply_stimulus(i_type(6'b100001, 5'd3), 1'b1, 32'h12, 32'd0);
    tick();
    complete(1, 32'h80FF00AA);
    valid_M = 1'b0;
    check_output("lh_hi_data", load_data, 32'hFFFF80FF);
    tick();
    apply_stimulus(i_type(6'b100101, 5'd3), 1'b1, 32'h10, 32'd0);
    tick();
    complete(0, 32'h80FF80AA);
    valid_M = 1'b0;
    check_output("lhu_lo_data", load_data, 32'h000080AA);
    tick();

    $display("[TB] stores and forwarding");
    apply_stimulus(i_type(6'b101000, 5'd5), 1'b1, 32'h22, 32'h000000C3);
    tick();
    check_output("sb_byteen", {28'd0, bus.mem_byteen}, 32'h4);
    check_output("sb_wdata", bus.mem_wdata, 32'hC3C3C3C3);
    check_output("sb_we", {31'd0, bus.mem_we}, 32'd1);
    check_output("sb_addr", bus.mem_addr, 32'h20);
    complete(0, 32'd0);
    valid_M = 1'b0;
    check_output("sb_no_load_valid", {31'd0, load_valid}, 32'd0);
    tick();
    apply_stimulus(i_type(6'b101001, 5'd5), 1'b1, 32'h22, 32'h1234ABCD);
    tick();
    check_output("sh_byteen", {28'd0, bus.mem_byteen}, 32'hC);
    check_output("sh_wdata", bus.mem_wdata, 32'hABCDABCD);
    complete(0, 32'd0);
    valid_M = 1'b0;
    tick();
    reg_addr_W = 5'd8;
    reg_data_W = 32'hDEADBEEF;
    apply_stimulus(i_type(6'b101011, 5'd8), 1'b1, 32'h30, 32'h11111111);
    check_output("sw_fwd", {31'd0, fwd_rt_data_M_op}, 32'd1);
    tick();
    check_output("sw_wdata_fwd", bus.mem_wdata, 32'hDEADBEEF);
    check_output("sw_byteen", {28'd0, bus.mem_byteen}, 32'hF);
    complete(0, 32'd0);
    valid_M = 1'b0;
    tick();
    reg_addr_W = 5'd0;
    apply_stimulus(i_type(6'b101011, 5'd0), 1'b0, 32'h30, 32'h11111111);
    check_output("rt0_no_fwd", {31'd0, fwd_rt_data_M_op}, 32'd0);

    $display("[TB] misaligned accesses");
    apply_stimulus(i_type(6'b100001, 5'd3), 1'b1, 32'h01, 32'd0);
    check_output("lh_adel", {31'd0, exc_adel}, 32'd1);
    check_output("lh_adel_stall", {31'd0, stall_M}, 32'd0);
    tick();
    check_output("lh_adel_no_req", {31'd0, bus.mem_req}, 32'd0);
    apply_stimulus(i_type(6'b101011, 5'd3), 1'b1, 32'h02, 32'd0);
    check_output("sw_ades", {31'd0, exc_ades}, 32'd1);
    check_output("sw_ades_no_adel", {31'd0, exc_adel}, 32'd0);
    apply_stimulus(i_type(6'b100000, 5'd3), 1'b1, 32'h03, 32'd0);
    check_output("lb_any_align", {31'd0, exc_adel}, 32'd0);
    valid_M = 1'b0;
    tick();

    $display("[TB] timeout on store");
    apply_stimulus(i_type(6'b101011, 5'd3), 1'b1, 32'h40, 32'd0);
    tick();
    repeat (14) tick();
    check_output("to_last_req", {31'd0, bus.mem_req}, 32'd1);
    check_output("to_no_err_yet", {31'd0, bus_err}, 32'd0);
    tick();
    valid_M = 1'b0;
    check_output("to_bus_err", {31'd0, bus_err}, 32'd1);
    check_output("to_req_clear", {31'd0, bus.mem_req}, 32'd0);
    check_output("to_load_data", load_data, 32'd0);
    tick();
    check_output("to_err_pulse", {31'd0, bus_err}, 32'd0);
    check_output("to_idle_stall", {31'd0, stall_M}, 32'd0);

    $display("[TB] ack on the timeout edge");
    apply_stimulus(i_type(6'b100011, 5'd3), 1'b1, 32'h44, 32'd0);
    tick();
    complete(14, 32'hCAFEF00D);
    valid_M = 1'b0;
    check_output("ack_edge_no_err", {31'd0, bus_err}, 32'd0);
    check_output("ack_edge_valid", {31'd0, load_valid}, 32'd1);
    check_output("ack_edge_data", load_data, 32'hCAFEF00D);
    tick();

    $display("[TB] reset during REQ");
    apply_stimulus(i_type(6'b100011, 5'd3), 1'b1, 32'h48, 32'd0);
    tick();
    check_output("rr_req_before", {31'd0, bus.mem_req}, 32'd1);
    reset = 1'b0;
    valid_M = 1'b0;
    #1;
    check_output("rr_req_cleared", {31'd0, bus.mem_req}, 32'd0);
    check_output("rr_addr_cleared", bus.mem_addr, 32'd0);
    check_output("rr_load_data", load_data, 32'd0);
    tick();
    reset = 1'b1;
    bus.mem_ack = 1'b1;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    check_output("rr_no_load_valid", {31'd0, load_valid}, 32'd0);
    check_output("rr_no_bus_err", {31'd0, bus_err}, 32'd0);
    check_output("rr_idle_stall", {31'd0, stall_M}, 32'd0);
    check_output("rr_idle_req", {31'd0, bus.mem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
